// File: rtl/cascade_pkg.sv
// Shared types and constants for the interrupt-acknowledge cascade sequencer.
package cascade_pkg;

  // Acknowledge sequencing states: idle, first INTA, second INTA.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CYC1 = 2'd1,
    CYC2 = 2'd2
  } cas_state_t;

  localparam logic MASTER = 1'b1;
  localparam logic SLAVE  = 1'b0;

endpackage

// File: rtl/cascade_timeout.sv
// Dwell counter: clears on state entry, counts while enabled, saturates at
// TIMEOUT-1 and flags expiry there.
module cascade_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Count dwell cycles; hold at LAST instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_en && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/cascade_sequencer.sv
// Cascade sequencer for a two-INTA interrupt acknowledge. The master drives
// the IR number onto the cascade lines when a slave sits on that IR; a slave
// drives the vector when the cascade lines carry its ID.
module cascade_sequencer
  import cascade_pkg::*;
#(
  parameter int CAS_W   = 3,
  parameter int N_IR    = 2**CAS_W,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sp_mode,
  input  logic [N_IR-1:0]  icw3,
  input  logic             ack_start,
  input  logic             ack_next,
  input  logic             ack_done,
  input  logic [CAS_W-1:0] ack_level,
  input  logic [CAS_W-1:0] cas_in,
  output logic [CAS_W-1:0] cas_out,
  output logic             cas_oe,
  output logic             vector_en,
  output logic             busy,
  output logic             proto_err
);

  cas_state_t       r_state;
  logic             r_mode;
  logic             r_present;
  logic [CAS_W-1:0] r_level;
  logic [CAS_W-1:0] r_cas;
  logic [CAS_W-1:0] r_id;
  logic [CAS_W-1:0] r_cas_out;
  logic             r_cas_oe;
  logic             r_vec;
  logic             r_busy;
  logic             r_err;

  cas_state_t w_nxt;
  logic       w_err;
  logic       w_expired;
  logic       w_present;
  logic       w_match;

  assign w_present = icw3[ack_level];
  assign w_match   = (r_cas == r_id);

  // Next-state and protocol-error decode; collisions and timeouts win over
  // the normal strobe transitions.
  always_comb begin
    w_nxt = r_state;
    w_err = 1'b0;
    if (ack_start && r_state != IDLE) w_err = 1'b1;
    if (ack_next  && r_state != CYC1) w_err = 1'b1;
    if (ack_done  && r_state != CYC2) w_err = 1'b1;
    if (ack_next && ack_done) begin
      w_err = 1'b1;
      w_nxt = IDLE;
    end else if (r_state != IDLE && w_expired) begin
      w_err = 1'b1;
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (ack_start) w_nxt = CYC1;
        CYC1:    if (ack_next)  w_nxt = CYC2;
        CYC2:    if (ack_done)  w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  cascade_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_nxt != r_state),
    .i_en      (r_state != IDLE),
    .o_expired (w_expired)
  );

  // State, captures and registered outputs. Everything the cycle depends on
  // is captured at ack_start so later sp_mode/icw3 changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= SLAVE;
      r_present <= 1'b0;
      r_level   <= '0;
      r_cas     <= '0;
      r_id      <= '0;
      r_cas_out <= '0;
      r_cas_oe  <= 1'b0;
      r_vec     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err;
      r_busy  <= (w_nxt != IDLE);
      if (w_nxt == IDLE) begin
        r_cas_out <= '0;
        r_cas_oe  <= 1'b0;
        r_vec     <= 1'b0;
      end else if (r_state == IDLE) begin
        r_mode    <= sp_mode;
        r_present <= w_present;
        r_level   <= ack_level;
        r_cas     <= cas_in;
        r_id      <= icw3[CAS_W-1:0];
        r_cas_oe  <= (sp_mode == MASTER) && w_present;
        r_cas_out <= ((sp_mode == MASTER) && w_present) ? ack_level : '0;
        r_vec     <= 1'b0;
      end else if (r_state == CYC1 && w_nxt == CYC2) begin
        r_cas_oe  <= (r_mode == MASTER) && r_present;
        r_cas_out <= ((r_mode == MASTER) && r_present) ? r_level : '0;
        r_vec     <= (r_mode == MASTER) ? !r_present : w_match;
      end
    end
  end

  assign cas_out   = r_cas_out;
  assign cas_oe    = r_cas_oe;
  assign vector_en = r_vec;
  assign busy      = r_busy;
  assign proto_err = r_err;

endmodule

// File: tb/tb_cascade_sequencer.sv
// Bench for cascade_sequencer: table of per-cycle vectors with expected
// outputs queued at drive time, plus hand-written reset sequences.
module tb_cascade_sequencer;

  localparam int CAS_W = 3;
  localparam int N_IR  = 8;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sp_mode, ack_start, ack_next, ack_done;
  logic [N_IR-1:0]  icw3;
  logic [CAS_W-1:0] ack_level, cas_in, cas_out;
  logic             cas_oe, vector_en, busy, proto_err;

  always #5 clk = ~clk;

  cascade_sequencer #(.CAS_W(CAS_W), .N_IR(N_IR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sp_mode(sp_mode), .icw3(icw3),
    .ack_start(ack_start), .ack_next(ack_next), .ack_done(ack_done),
    .ack_level(ack_level), .cas_in(cas_in), .cas_out(cas_out),
    .cas_oe(cas_oe), .vector_en(vector_en), .busy(busy), .proto_err(proto_err)
  );

  // Observed outputs: {cas_out, cas_oe, vector_en, busy, proto_err}
  wire [6:0] w_obs = {cas_out, cas_oe, vector_en, busy, proto_err};

  typedef struct {
    string      nm;
    logic       st, nx, dn, md;
    logic [7:0] icw;
    logic [2:0] lvl, cin;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] sb[$];
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic logic [6:0] E(logic [2:0] co, logic oe, logic ve, logic bz, logic er);
    return {co, oe, ve, bz, er};
  endfunction

  function automatic vec_t mk(string nm, logic st, logic nx, logic dn, logic md,
                              logic [7:0] icw, logic [2:0] lvl, logic [2:0] cin,
                              logic [6:0] e);
    vec_t v;
    v.nm = nm; v.st = st; v.nx = nx; v.dn = dn; v.md = md;
    v.icw = icw; v.lvl = lvl; v.cin = cin; v.exp = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b ({cas_out,oe,vec,busy,err})", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    ack_start = v.st; ack_next = v.nx; ack_done = v.dn; sp_mode = v.md;
    icw3 = v.icw; ack_level = v.lvl; cas_in = v.cin;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk({v.nm, "_sb_empty"}, 7'h7f, 7'h00);
    else                chk(v.nm, w_obs, sb.pop_front());
  endtask

  initial begin
    logic [6:0] Z;
    logic [6:0] M2;
    logic [6:0] BZ;
    Z  = E(3'd0, 0, 0, 0, 0);
    M2 = E(3'd2, 1, 0, 1, 0);
    BZ = E(3'd0, 0, 0, 1, 0);

    rst_n = 1'b1; sp_mode = 1'b0; icw3 = '0; ack_level = '0; cas_in = '0;
    ack_start = 1'b0; ack_next = 1'b0; ack_done = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_state", w_obs, Z);
    @(negedge clk);
    rst_n = 1'b1;

    // Master, slave on IR2; sp_mode/icw3 disturbed mid-cycle must not matter.
    tbl.push_back(mk("m_pres_start", 1,0,0, 1, 8'h04, 3'd2, 3'd0, M2));
    tbl.push_back(mk("m_pres_dwell", 0,0,0, 1, 8'h04, 3'd2, 3'd0, M2));
    tbl.push_back(mk("m_pres_next",  0,1,0, 0, 8'h00, 3'd5, 3'd0, M2));
    tbl.push_back(mk("m_pres_done",  0,0,1, 1, 8'h04, 3'd2, 3'd0, Z));
    // Master, no slave on IR5: this device supplies the vector.
    tbl.push_back(mk("m_nosl_start", 1,0,0, 1, 8'h04, 3'd5, 3'd0, BZ));
    tbl.push_back(mk("m_nosl_next",  0,1,0, 1, 8'h04, 3'd5, 3'd0, E(3'd0,0,1,1,0)));
    tbl.push_back(mk("m_nosl_done",  0,0,1, 1, 8'h04, 3'd5, 3'd0, Z));
    // Slave ID 3, cascade carries 3; inputs change after capture.
    tbl.push_back(mk("s_hit_start",  1,0,0, 0, 8'h03, 3'd0, 3'd3, BZ));
    tbl.push_back(mk("s_hit_next",   0,1,0, 1, 8'h05, 3'd0, 3'd0, E(3'd0,0,1,1,0)));
    tbl.push_back(mk("s_hit_done",   0,0,1, 0, 8'h03, 3'd0, 3'd3, Z));
    // Slave ID 3, cascade carries 4: not selected.
    tbl.push_back(mk("s_miss_start", 1,0,0, 0, 8'h03, 3'd0, 3'd4, BZ));
    tbl.push_back(mk("s_miss_next",  0,1,0, 0, 8'h03, 3'd0, 3'd3, BZ));
    tbl.push_back(mk("s_miss_done",  0,0,1, 0, 8'h03, 3'd0, 3'd4, Z));
    // Duplicate start in CYC1, then next+done collision in CYC2.
    tbl.push_back(mk("dup_start1",   1,0,0, 1, 8'h04, 3'd2, 3'd0, M2));
    tbl.push_back(mk("dup_start2",   1,0,0, 1, 8'h04, 3'd2, 3'd0, E(3'd2,1,0,1,1)));
    tbl.push_back(mk("dup_next",     0,1,0, 1, 8'h04, 3'd2, 3'd0, M2));
    tbl.push_back(mk("collide",      0,1,1, 1, 8'h04, 3'd2, 3'd0, E(3'd0,0,0,0,1)));
    tbl.push_back(mk("collide_post", 0,0,0, 1, 8'h04, 3'd2, 3'd0, Z));
    // Stray strobes while idle.
    tbl.push_back(mk("idle_done",    0,0,1, 1, 8'h04, 3'd2, 3'd0, E(3'd0,0,0,0,1)));
    tbl.push_back(mk("idle_next",    0,1,0, 1, 8'h04, 3'd2, 3'd0, E(3'd0,0,0,0,1)));
    tbl.push_back(mk("idle_quiet",   0,0,0, 1, 8'h04, 3'd2, 3'd0, Z));
    // Timeout: start then silence; abort on the 8th edge after start.
    tbl.push_back(mk("to_start",     1,0,0, 1, 8'h04, 3'd2, 3'd0, M2));
    for (int i = 1; i < TO; i++)
      tbl.push_back(mk($sformatf("to_dwell%0d", i), 0,0,0, 1, 8'h04, 3'd2, 3'd0, M2));
    tbl.push_back(mk("to_expire",    0,0,0, 1, 8'h04, 3'd2, 3'd0, E(3'd0,0,0,0,1)));
    tbl.push_back(mk("to_after",     0,0,0, 1, 8'h04, 3'd2, 3'd0, Z));
    // Timeout also applies in CYC2 (dwell restarts on entry).
    tbl.push_back(mk("to2_start",    1,0,0, 1, 8'h04, 3'd5, 3'd0, BZ));
    tbl.push_back(mk("to2_next",     0,1,0, 1, 8'h04, 3'd5, 3'd0, E(3'd0,0,1,1,0)));
    for (int i = 1; i < TO; i++)
      tbl.push_back(mk($sformatf("to2_dwell%0d", i), 0,0,0, 1, 8'h04, 3'd5, 3'd0, E(3'd0,0,1,1,0)));
    tbl.push_back(mk("to2_expire",   0,0,0, 1, 8'h04, 3'd5, 3'd0, E(3'd0,0,0,0,1)));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset in the middle of CYC2 with cascade driven: outputs drop at once.
    apply(mk("rst_seq_start", 1,0,0, 1, 8'h04, 3'd2, 3'd0, M2));
    apply(mk("rst_seq_next",  0,1,0, 1, 8'h04, 3'd2, 3'd0, M2));
    @(negedge clk);
    ack_start = 1'b0; ack_next = 1'b0; ack_done = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc2", w_obs, Z);
    // Release reset with ack_start already present: first edge must take it.
    @(negedge clk);
    rst_n = 1'b1;
    ack_start = 1'b1; sp_mode = 1'b1; icw3 = 8'h04; ack_level = 3'd2;
    @(posedge clk);
    #1;
    chk("start_after_rst", w_obs, M2);
    apply(mk("post_rst_next", 0,1,0, 1, 8'h04, 3'd2, 3'd0, M2));
    apply(mk("post_rst_done", 0,0,1, 1, 8'h04, 3'd2, 3'd0, Z));

    if (sb.size() != 0) chk("sb_drained", 7'(sb.size()), 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cascade_sequencer.md
CASCADE_SEQUENCER -- requirements
Module: cascade_sequencer

Interface
REQ-001 The block SHALL have parameter CAS_W, default 3, meaning cascade-line width.
REQ-002 The block SHALL have parameter N_IR, default 2**CAS_W, meaning IR inputs per device, equal to the ICW3 width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles spent in an acknowledge state before abort; the minimum value is 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sp_mode, input, 1 bit: 1 selects MASTER, 0 selects SLAVE.
REQ-007 The block SHALL have port icw3, input, N_IR bits: in MASTER, a slave-present mask per IR; in SLAVE, bits [CAS_W-1:0] hold the slave ID.
REQ-008 The block SHALL have port ack_start, input, 1 bit: a one-cycle strobe marking the first INTA.
REQ-009 The block SHALL have port ack_next, input, 1 bit: a one-cycle strobe marking the second INTA.
REQ-010 The block SHALL have port ack_done, input, 1 bit: a one-cycle strobe marking the end of the second INTA.
REQ-011 The block SHALL have port ack_level, input, CAS_W bits: the IR being acknowledged (MASTER only).
REQ-012 The block SHALL have port cas_in, input, CAS_W bits: the sampled cascade lines.
REQ-013 The block SHALL have port cas_out, output, CAS_W bits: the driven cascade value.
REQ-014 The block SHALL have port cas_oe, output, 1 bit: the cascade output enable.
REQ-015 The block SHALL have port vector_en, output, 1 bit: asserted when this device drives the vector.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted whenever the state is not IDLE.
REQ-017 The block SHALL have port proto_err, output, 1 bit: a one-cycle error pulse.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, CYC1 and CYC2.
REQ-019 In IDLE, ack_start SHALL cause a transition to CYC1 on the next edge, capturing sp_mode, ack_level and cas_in into internal registers.
REQ-020 In CYC1, ack_next SHALL cause a transition to CYC2; in CYC2, ack_done SHALL cause a transition to IDLE.
REQ-021 In MASTER mode, when icw3[ack_level]=1, cas_out SHALL equal the captured level and cas_oe SHALL be 1 throughout CYC1 and CYC2, with vector_en held at 0.
REQ-022 In MASTER mode, when icw3[ack_level]=0, cas_oe SHALL be 0 and vector_en SHALL be 1 throughout CYC2.
REQ-023 In SLAVE mode, a match flag SHALL be set to (captured cas_in == icw3[CAS_W-1:0]); vector_en SHALL equal the match flag throughout CYC2, and cas_oe SHALL stay 0.
REQ-024 Outputs SHALL be registered, giving a latency of 1 cycle from the strobe to the output change.
REQ-025 Changes to sp_mode or icw3 after capture SHALL NOT affect the cycle in progress.
REQ-026 ack_start outside IDLE SHALL be ignored and SHALL pulse proto_err.
REQ-027 ack_next outside CYC1, or ack_done outside CYC2, SHALL be ignored and SHALL pulse proto_err.
REQ-028 ack_next and ack_done asserted in the same cycle SHALL pulse proto_err and force a return to IDLE.
REQ-029 A dwell counter SHALL clear on each state entry and increment each cycle spent in CYC1 or CYC2.
REQ-030 When the dwell counter reaches TIMEOUT-1, the FSM SHALL return to IDLE, pulse proto_err, and drop cas_oe and vector_en.
REQ-031 The dwell counter SHALL saturate and never wrap.

Reset
REQ-032 While rst_n=0, the block SHALL hold state IDLE, with cas_out=0, cas_oe=0, vector_en=0, busy=0, proto_err=0, and the counter and captures at 0.
REQ-033 Reset asserted mid-acknowledge SHALL immediately release cas_oe and vector_en.
REQ-034 After reset release, the block SHALL respond to ack_start from the first clock edge.

Structure
REQ-035 A shared package cascade_pkg SHALL hold the state typedef (IDLE/CYC1/CYC2) and the MASTER=1 and SLAVE=0 constants.
REQ-036 The dwell counter SHALL be a sub-module named cascade_timeout, parametrised by TIMEOUT, with clear and enable inputs and an expired output.

Verification
REQ-037 In MASTER mode with icw3=8'h04 and ack_level=2: start, next, done -> cas_out=3'd2, cas_oe=1 over CYC1 and CYC2, and vector_en=0.
REQ-038 In MASTER mode with icw3=8'h04 and ack_level=5 -> cas_oe=0, and vector_en=1 only in CYC2.
REQ-039 In SLAVE mode with icw3=8'h03: cas_in=3 -> vector_en=1 in CYC2; cas_in=4 -> vector_en stays 0.
REQ-040 With TIMEOUT=8, ack_start followed by no further strobes -> proto_err pulses after 8 cycles, the state returns to IDLE and cas_oe=0.
REQ-041 A second ack_start while in CYC1, then ack_next and ack_done asserted together in CYC2 -> proto_err pulses for each, and the FSM is in IDLE after the second event.
REQ-042 Asserting rst_n=0 during CYC2 with cas_oe=1 -> all outputs read 0 before the next clock edge.
